// File: rtl/vcounter_pkg.sv
// rtl/vcounter_pkg.sv - opcode and state encodings for the extended counter
package vcounter_pkg;

  localparam logic [2:0] OP_NONE      = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_INCR      = 3'd2;
  localparam logic [2:0] OP_DECR      = 3'd3;
  localparam logic [2:0] OP_SET_LIMIT = 3'd4;
  localparam logic [2:0] OP_RUN_UP    = 3'd5;
  localparam logic [2:0] OP_RUN_DOWN  = 3'd6;
  localparam logic [2:0] OP_STOP      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/vcounter_if.sv
// rtl/vcounter_if.sv - command/status bundle between a controller and the counter
interface vcounter_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit_in;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] limit_out;
  logic             running;
  logic             at_zero;
  logic             at_limit;
  logic             evt;

  modport master (
    output data_in, step, limit_in, ctrl,
    input  data_out, limit_out, running, at_zero, at_limit, evt
  );

  modport slave (
    input  data_in, step, limit_in, ctrl,
    output data_out, limit_out, running, at_zero, at_limit, evt
  );

endinterface

// File: rtl/vcounter_step.sv
// rtl/vcounter_step.sv - one up/down step against a limit, wrap or clamp on overflow
module vcounter_step #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;

  // Extra bit keeps value + step exact so the limit compare never aliases
  assign w_sum = {1'b0, i_value} + {1'b0, i_step};

  always_comb begin
    o_next = i_value;
    o_ovf  = 1'b0;
    if (i_up) begin
      if (w_sum > {1'b0, i_limit}) begin
        o_ovf  = 1'b1;
        o_next = (SATURATE != 0) ? i_limit : '0;
      end else begin
        o_next = w_sum[WIDTH-1:0];
      end
    end else begin
      if (i_value < i_step) begin
        o_ovf  = 1'b1;
        o_next = (SATURATE != 0) ? '0 : i_limit;
      end else begin
        o_next = i_value - i_step;
      end
    end
  end

endmodule

// File: rtl/vcounter_ext.sv
// rtl/vcounter_ext.sv - up/down counter with step, limit, wrap/saturate and run modes
module vcounter_ext
  import vcounter_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SATURATE    = 0,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic        clk,
  input logic        async_nreset,
  vcounter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_VAL =
    (WIDTH < 32 && RESET_VALUE > (2**WIDTH - 1)) ? {WIDTH{1'b1}} : WIDTH'(RESET_VALUE);

  state_t           r_state;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_limit;
  logic             r_running;
  logic             r_evt;

  logic             w_up;
  logic             w_do_step;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf;

  // Explicit opcodes take priority; NONE falls back to the run direction
  always_comb begin
    w_up      = 1'b0;
    w_do_step = 1'b0;
    case (bus.ctrl)
      OP_INCR, OP_RUN_UP: begin
        w_up      = 1'b1;
        w_do_step = 1'b1;
      end
      OP_DECR, OP_RUN_DOWN: w_do_step = 1'b1;
      OP_NONE: begin
        w_up      = (r_state == ST_RUN_UP);
        w_do_step = (r_state != ST_IDLE);
      end
      default: begin
      end
    endcase
  end

  vcounter_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .i_value (r_value),
    .i_step  (bus.step),
    .i_limit (r_limit),
    .i_up    (w_up),
    .o_next  (w_next),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state   <= ST_IDLE;
      r_value   <= RST_VAL;
      r_limit   <= '1;
      r_running <= 1'b0;
      r_evt     <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (w_do_step) begin
        r_value <= w_next;
        r_evt   <= w_ovf;
      end
      case (bus.ctrl)
        OP_LOAD: r_value <= (bus.data_in > r_limit) ? r_limit : bus.data_in;
        OP_SET_LIMIT: begin
          r_limit <= bus.limit_in;
          if (r_value > bus.limit_in) r_value <= bus.limit_in;
        end
        OP_RUN_UP: begin
          r_state   <= ST_RUN_UP;
          r_running <= 1'b1;
        end
        OP_RUN_DOWN: begin
          r_state   <= ST_RUN_DOWN;
          r_running <= 1'b1;
        end
        OP_STOP: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
        default: begin
        end
      endcase
      // Saturating runs are one-shot: hitting a bound ends the run
      if (SATURATE != 0 && w_do_step && w_ovf) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_value;
  assign bus.limit_out = r_limit;
  assign bus.running   = r_running;
  assign bus.evt       = r_evt;
  assign bus.at_zero   = (r_value == '0);
  assign bus.at_limit  = (r_value == r_limit);

endmodule

// File: tb/tb_vcounter_ext.sv
// tb/tb_vcounter_ext.sv - scoreboard bench for wrap and saturate counter instances
module tb_vcounter_ext;
  import vcounter_pkg::*;

  typedef struct {
    bit       sel;
    logic [7:0] v;
    logic [7:0] l;
    logic       r;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] stp = '0;
  logic [7:0] lim = '0;
  logic [2:0] op = OP_NONE;
  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  vcounter_if #(.WIDTH(8)) bus_w ();
  vcounter_if #(.WIDTH(8)) bus_s ();

  assign bus_w.data_in = din;
  assign bus_w.step = stp;
  assign bus_w.limit_in = lim;
  assign bus_w.ctrl = op;
  assign bus_s.data_in = din;
  assign bus_s.step = stp;
  assign bus_s.limit_in = lim;
  assign bus_s.ctrl = op;

  vcounter_ext #(.WIDTH(8), .SATURATE(0), .RESET_VALUE(0)) u_wrap (
    .clk(clk), .async_nreset(rst_n), .bus(bus_w.slave));
  vcounter_ext #(.WIDTH(8), .SATURATE(1), .RESET_VALUE(0)) u_sat (
    .clk(clk), .async_nreset(rst_n), .bus(bus_s.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input bit sel, input string tag, input exp_t x);
    logic [7:0] v, l;
    logic r, e, z, a;
    v = sel ? bus_s.data_out  : bus_w.data_out;
    l = sel ? bus_s.limit_out : bus_w.limit_out;
    r = sel ? bus_s.running   : bus_w.running;
    e = sel ? bus_s.evt       : bus_w.evt;
    z = sel ? bus_s.at_zero   : bus_w.at_zero;
    a = sel ? bus_s.at_limit  : bus_w.at_limit;
    check({tag, ".data"}, 32'(v), 32'(x.v));
    check({tag, ".limit"}, 32'(l), 32'(x.l));
    check({tag, ".run"}, 32'(r), 32'(x.r));
    check({tag, ".evt"}, 32'(e), 32'(x.e));
    check({tag, ".zero"}, 32'(z), 32'(x.v == 8'd0));
    check({tag, ".atlim"}, 32'(a), 32'(x.v == x.l));
  endtask

  task automatic step_op(input bit sel, input string tag, input logic [2:0] o,
                         input logic [7:0] d, input logic [7:0] s, input logic [7:0] li,
                         input logic [7:0] ev, input logic [7:0] el,
                         input logic er, input logic ee);
    exp_t x;
    @(negedge clk);
    op = o; din = d; stp = s; lim = li;
    x.sel = sel; x.v = ev; x.l = el; x.r = er; x.e = ee;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_dut(x.sel, tag, x);
    end
  endtask

  initial begin
    exp_t rx;
    rx.sel = 0; rx.v = 8'd0; rx.l = 8'hFF; rx.r = 1'b0; rx.e = 1'b0;
    #12;
    check_dut(0, "rst_w", rx);
    check_dut(1, "rst_s", rx);
    rst_n = 1'b1;

    // wrap overflow on INCR, then step of 0
    step_op(0, "setlim10", OP_SET_LIMIT, 0, 0, 10,   0, 10, 0, 0);
    step_op(0, "load8",    OP_LOAD,      8, 0, 0,    8, 10, 0, 0);
    step_op(0, "incr_ovf", OP_INCR,      0, 3, 0,    0, 10, 0, 1);
    step_op(0, "incr3",    OP_INCR,      0, 3, 0,    3, 10, 0, 0);
    step_op(0, "incr0",    OP_INCR,      0, 0, 0,    3, 10, 0, 0);

    // periodic RUN_DOWN with wrap to limit
    step_op(0, "setlim5",  OP_SET_LIMIT, 0, 0, 5,    3, 5, 0, 0);
    step_op(0, "rdn1",     OP_RUN_DOWN,  0, 2, 0,    1, 5, 1, 0);
    step_op(0, "rdn_udf",  OP_NONE,      0, 2, 0,    5, 5, 1, 1);
    step_op(0, "rdn3",     OP_NONE,      0, 2, 0,    3, 5, 1, 0);
    step_op(0, "rdn1b",    OP_NONE,      0, 2, 0,    1, 5, 1, 0);
    step_op(0, "rdn_udf2", OP_NONE,      0, 2, 0,    5, 5, 1, 1);
    step_op(0, "stop",     OP_STOP,      0, 2, 0,    5, 5, 0, 0);
    step_op(0, "hold",     OP_NONE,      0, 2, 0,    5, 5, 0, 0);

    // load clamp and limit shrink clamp
    step_op(0, "setlim100", OP_SET_LIMIT, 0, 0, 100, 5, 100, 0, 0);
    step_op(0, "load200",   OP_LOAD,    200, 0, 0,   100, 100, 0, 0);
    step_op(0, "setlim50",  OP_SET_LIMIT, 0, 0, 50,  50, 50, 0, 0);

    // explicit opcode overrides the run step for one cycle
    step_op(0, "load0",    OP_LOAD,   0, 1, 0,   0, 50, 0, 0);
    step_op(0, "rup1",     OP_RUN_UP, 0, 1, 0,   1, 50, 1, 0);
    step_op(0, "rup2",     OP_NONE,   0, 1, 0,   2, 50, 1, 0);
    step_op(0, "decr_mid", OP_DECR,   0, 1, 0,   1, 50, 1, 0);
    step_op(0, "rup2b",    OP_NONE,   0, 1, 0,   2, 50, 1, 0);
    step_op(0, "incr0run", OP_INCR,   0, 0, 0,   2, 50, 1, 0);
    step_op(0, "stop2",    OP_STOP,   0, 0, 0,   2, 50, 0, 0);

    // limit 0: any up step overflows
    step_op(0, "setlim0",  OP_SET_LIMIT, 0, 0, 0, 0, 0, 0, 0);
    step_op(0, "lim0_ovf", OP_INCR,      0, 1, 0, 0, 0, 0, 1);

    // saturating one-shot runs on the second instance
    step_op(1, "s_setlim", OP_SET_LIMIT, 0, 0, 10, 0, 10, 0, 0);
    step_op(1, "s_load9",  OP_LOAD,      9, 0, 0,  9, 10, 0, 0);
    step_op(1, "s_rup",    OP_RUN_UP,    0, 1, 0,  10, 10, 1, 0);
    step_op(1, "s_ovf",    OP_NONE,      0, 1, 0,  10, 10, 0, 1);
    step_op(1, "s_hold",   OP_NONE,      0, 1, 0,  10, 10, 0, 0);
    step_op(1, "s_rdn6",   OP_RUN_DOWN,  0, 4, 0,  6, 10, 1, 0);
    step_op(1, "s_rdn2",   OP_NONE,      0, 4, 0,  2, 10, 1, 0);
    step_op(1, "s_udf",    OP_NONE,      0, 4, 0,  0, 10, 0, 1);
    step_op(1, "s_hold0",  OP_NONE,      0, 4, 0,  0, 10, 0, 0);

    // asynchronous reset mid-cycle while running
    @(negedge clk);
    op = OP_RUN_UP; stp = 8'd1;
    @(posedge clk);
    #1;
    check("pre_rst_run", 32'(bus_w.running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_dut(0, "arst_w", rx);
    check_dut(1, "arst_s", rx);
    op = OP_NONE;
    #10;
    rst_n = 1'b1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vcounter_ext.md
Name: vcounter_ext

Overview:
Parametrised up/down counter register with programmable step, programmable upper limit, wrap or saturate overflow mode, and free-running RUN_UP/RUN_DOWN modes. It succeeds the simple NONE/LOAD/INCR/DECR register used in datapath and timer slots. It adds an event pulse and zero/limit flags so control FSMs can use it as a timer or address generator without external compare logic.

Parameters:
WIDTH, 8, bit width of counter value, step and limit (>= 2)
SATURATE, 0, 0 = wrap on overflow/underflow, 1 = clamp at bound
RESET_VALUE, 0, counter value after reset (must be <= 2^WIDTH-1)

Ports:
clk  input  1  clock, all state updates on rising edge
async_nreset  input  1  asynchronous active-low reset
data_in  input  WIDTH  load value for LOAD
step  input  WIDTH  increment/decrement amount, sampled every cycle a step occurs
limit_in  input  WIDTH  new limit for SET_LIMIT
ctrl  input  3  opcode: 0 NONE, 1 LOAD, 2 INCR, 3 DECR, 4 SET_LIMIT, 5 RUN_UP, 6 RUN_DOWN, 7 STOP
data_out  output  WIDTH  current counter value (registered)
limit_out  output  WIDTH  current limit (registered)
running  output  1  high while in RUN_UP or RUN_DOWN state
at_zero  output  1  data_out == 0 (combinational from register)
at_limit  output  1  data_out == limit_out (combinational from register)
event  output  1  registered one-cycle pulse: overflow/underflow occurred on the update that produced the current data_out

Behaviour:
- Reset (async, immediate): data_out = RESET_VALUE clamped to all-ones, limit_out = all-ones, state IDLE, running = 0, event = 0.
- State machine: IDLE, RUN_UP, RUN_DOWN. RUN_UP/RUN_DOWN opcodes enter the state and perform one step in that same cycle. STOP goes to IDLE with no step. Other opcodes leave the state unchanged.
- ctrl NONE in IDLE: hold. ctrl NONE in RUN_UP/RUN_DOWN: one up/down step per cycle.
- Explicit opcode in a run state overrides the automatic step for that cycle only. LOAD, INCR, DECR and SET_LIMIT execute as in IDLE and running stays set.
- Latency: every operation visible on data_out/limit_out/event one cycle after the edge that samples ctrl.
- Step arithmetic in WIDTH+1 bits, no truncation:
  - up: sum = value + step. If sum > limit: overflow. Wrap mode gives 0; saturate mode gives limit.
  - down: if value < step: underflow. Wrap mode gives limit; saturate mode gives 0. Otherwise the result is value - step.
  - step == 0: value unchanged, no event.
- event = 1 for exactly the cycle following an overflow/underflow update; otherwise 0. Back-to-back overflows keep event high.
- Saturate mode while running: an overflow/underflow forces state IDLE on the same edge (one-shot). Wrap mode keeps running (periodic).
- LOAD: data_in > limit loads limit. No event.
- SET_LIMIT: limit <= limit_in. If current value > limit_in, value is clamped to limit_in on the same edge. No event.
- Limit 0 is legal. Any up step of 1 or more overflows.

Decomposition:
- Package vcounter_pkg: opcode localparams (OP_NONE..OP_STOP), state encoding (ST_IDLE, ST_RUN_UP, ST_RUN_DOWN).
- One sub-module vcounter_step: combinational, inputs value/step/limit/direction/SATURATE, outputs next value and overflow flag. Instantiated once, with direction chosen by opcode/state.

Test Plan:
- Async reset asserted mid-cycle while running -> data_out 0, limit_out 0xFF, running 0, event 0 immediately, without waiting for a clock.
- WIDTH=8 wrap: SET_LIMIT 10, LOAD 8, INCR step 3 -> data_out 0, event 1 for one cycle; INCR step 3 again -> 3, event 0.
- SATURATE=1: limit 10, LOAD 9, RUN_UP step 1 -> 10 (event 0, running 1), next cycle 10 with event 1 and running 0, then holds 10.
- Wrap RUN_DOWN step 2, limit 5, from 3 -> 1, 5 (event 1), 3, 1, 5 ...; STOP -> value holds, running 0.
- Limit 100, LOAD 200 -> 100; SET_LIMIT 50 -> data_out 50, limit_out 50, at_limit 1, event 0.
- RUN_UP step 1 from 0, then DECR step 1 mid-run -> sequence 1, 2, 1, 2, running stays 1. INCR step 0 -> no change, no event.
